// File: rtl/control_sequencer_pkg.sv
// Shared ASAP-1 definitions: opcode nibbles, T-state encoding and the control word.
package asap1_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } tstate_t;

  // Bit order from MSB: pc_oe down to out_ie; the CPU top level slices this word directly.
  typedef struct packed {
    logic pc_oe;
    logic pc_ie;
    logic pc_step;
    logic mar_ie;
    logic ram_oe;
    logic ram_we;
    logic ir_ie;
    logic a_ie;
    logic a_oe;
    logic b_ie;
    logic alu_oe;
    logic alu_sub;
    logic flags_ie;
    logic out_ie;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NONE = '0;

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational microcode: (T-state, opcode nibble, flags) -> control word + last-step marker.
module control_decode
  import asap1_pkg::*;
(
  input  logic [2:0]  i_tstate,
  input  logic [3:0]  i_op,
  input  logic        i_flag_c,
  input  logic        i_flag_z,
  output ctrl_word_t  o_ctrl,
  output logic        o_last_step
);

  // Decode one microstep; unlisted opcodes fall through to NOP (last step at T2).
  always_comb begin
    o_ctrl      = CTRL_NONE;
    o_last_step = 1'b0;
    if (i_tstate == T0) begin
      o_ctrl.pc_oe  = 1'b1;
      o_ctrl.mar_ie = 1'b1;
    end else if (i_tstate == T1) begin
      o_ctrl.ram_oe  = 1'b1;
      o_ctrl.ir_ie   = 1'b1;
      o_ctrl.pc_step = 1'b1;
    end else if (i_tstate == T2) begin
      case (i_op)
        OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP, OP_JC, OP_JZ: begin
          o_ctrl.pc_oe  = 1'b1;
          o_ctrl.mar_ie = 1'b1;
        end
        OP_OUT: begin
          o_ctrl.a_oe   = 1'b1;
          o_ctrl.out_ie = 1'b1;
          o_last_step   = 1'b1;
        end
        default: o_last_step = 1'b1;
      endcase
    end else if (i_tstate == T3) begin
      case (i_op)
        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
          o_ctrl.ram_oe  = 1'b1;
          o_ctrl.mar_ie  = 1'b1;
          o_ctrl.pc_step = 1'b1;
        end
        OP_LDI: begin
          o_ctrl.ram_oe  = 1'b1;
          o_ctrl.a_ie    = 1'b1;
          o_ctrl.pc_step = 1'b1;
          o_last_step    = 1'b1;
        end
        OP_JMP, OP_JC, OP_JZ: begin
          // Taken jump loads PC from the operand; not-taken just steps over it.
          if ((i_op == OP_JMP) || (i_op == OP_JC && i_flag_c) || (i_op == OP_JZ && i_flag_z)) begin
            o_ctrl.ram_oe = 1'b1;
            o_ctrl.pc_ie  = 1'b1;
          end else begin
            o_ctrl.pc_step = 1'b1;
          end
          o_last_step = 1'b1;
        end
        default: o_last_step = 1'b1;
      endcase
    end else if (i_tstate == T4) begin
      case (i_op)
        OP_LDA: begin
          o_ctrl.ram_oe = 1'b1;
          o_ctrl.a_ie   = 1'b1;
          o_last_step   = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          o_ctrl.ram_oe = 1'b1;
          o_ctrl.b_ie   = 1'b1;
        end
        OP_STA: begin
          o_ctrl.a_oe   = 1'b1;
          o_ctrl.ram_we = 1'b1;
          o_last_step   = 1'b1;
        end
        default: o_last_step = 1'b1;
      endcase
    end else if (i_tstate == T5) begin
      if (i_op == OP_ADD || i_op == OP_SUB) begin
        o_ctrl.alu_oe   = 1'b1;
        o_ctrl.a_ie     = 1'b1;
        o_ctrl.flags_ie = 1'b1;
        o_ctrl.alu_sub  = (i_op == OP_SUB);
      end
      o_last_step = 1'b1;
    end else begin
      o_last_step = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// ASAP-1 control sequencer: T-state counter, halt latch and gating of the decoded control word.
module control_sequencer
  import asap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       pc_oe,
  output logic       pc_ie,
  output logic       pc_step,
  output logic       mar_ie,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       ir_ie,
  output logic       a_ie,
  output logic       a_oe,
  output logic       b_ie,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       flags_ie,
  output logic       out_ie,
  output logic       halted,
  output logic [2:0] tstate
);

  tstate_t    r_tstate;
  logic       r_halted;
  ctrl_word_t w_ctrl_dec;
  ctrl_word_t w_ctrl;
  logic       w_last_step;
  logic       w_opcode_unused;

  // Operand bits of the IR carry addresses/immediates, not control.
  assign w_opcode_unused = ^opcode[3:0];

  control_decode u_decode (
    .i_tstate    (r_tstate),
    .i_op        (opcode[7:4]),
    .i_flag_c    (flag_c),
    .i_flag_z    (flag_z),
    .o_ctrl      (w_ctrl_dec),
    .o_last_step (w_last_step)
  );

  // T-state sequencing and halt latch; HLT parks the counter at T0 until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tstate <= T0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (r_tstate == T2 && opcode[7:4] == OP_HLT) begin
        r_halted <= 1'b1;
        r_tstate <= T0;
      end else if (w_last_step) begin
        r_tstate <= T0;
      end else begin
        case (r_tstate)
          T0:      r_tstate <= T1;
          T1:      r_tstate <= T2;
          T2:      r_tstate <= T3;
          T3:      r_tstate <= T4;
          T4:      r_tstate <= T5;
          default: r_tstate <= T0;
        endcase
      end
    end
  end

  // Reset and halt force every strobe low within the same cycle.
  assign w_ctrl = (rst || r_halted) ? CTRL_NONE : w_ctrl_dec;

  assign pc_oe    = w_ctrl.pc_oe;
  assign pc_ie    = w_ctrl.pc_ie;
  assign pc_step  = w_ctrl.pc_step;
  assign mar_ie   = w_ctrl.mar_ie;
  assign ram_oe   = w_ctrl.ram_oe;
  assign ram_we   = w_ctrl.ram_we;
  assign ir_ie    = w_ctrl.ir_ie;
  assign a_ie     = w_ctrl.a_ie;
  assign a_oe     = w_ctrl.a_oe;
  assign b_ie     = w_ctrl.b_ie;
  assign alu_oe   = w_ctrl.alu_oe;
  assign alu_sub  = w_ctrl.alu_sub;
  assign flags_ie = w_ctrl.flags_ie;
  assign out_ie   = w_ctrl.out_ie;
  assign halted   = r_halted;
  assign tstate   = r_tstate;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-written expected control words.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] opcode;
  logic       flag_c, flag_z;
  logic       pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_we, ir_ie;
  logic       a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie;
  logic       halted;
  logic [2:0] tstate;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side ordering of the strobes, independent of the RTL struct.
  localparam logic [13:0] PC_OE    = 14'h2000;
  localparam logic [13:0] PC_IE    = 14'h1000;
  localparam logic [13:0] PC_STEP  = 14'h0800;
  localparam logic [13:0] MAR_IE   = 14'h0400;
  localparam logic [13:0] RAM_OE   = 14'h0200;
  localparam logic [13:0] RAM_WE   = 14'h0100;
  localparam logic [13:0] IR_IE    = 14'h0080;
  localparam logic [13:0] A_IE     = 14'h0040;
  localparam logic [13:0] A_OE     = 14'h0020;
  localparam logic [13:0] B_IE     = 14'h0010;
  localparam logic [13:0] ALU_OE   = 14'h0008;
  localparam logic [13:0] ALU_SUB  = 14'h0004;
  localparam logic [13:0] FLAGS_IE = 14'h0002;
  localparam logic [13:0] OUT_IE   = 14'h0001;
  localparam logic [13:0] NONE     = 14'h0000;

  wire [13:0] ctrl = {pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_we, ir_ie,
                      a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie};

  control_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .pc_oe(pc_oe), .pc_ie(pc_ie), .pc_step(pc_step), .mar_ie(mar_ie),
    .ram_oe(ram_oe), .ram_we(ram_we), .ir_ie(ir_ie), .a_ie(a_ie), .a_oe(a_oe),
    .b_ie(b_ie), .alu_oe(alu_oe), .alu_sub(alu_sub), .flags_ie(flags_ie),
    .out_ie(out_ie), .halted(halted), .tstate(tstate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check state and strobes of the current cycle, then move to just after the next edge.
  task automatic cyc(input string tag, input logic [2:0] exp_t, input logic [13:0] exp_c);
    #1;
    chk({tag, "_t"}, {29'd0, tstate}, {29'd0, exp_t});
    chk({tag, "_c"}, {18'd0, ctrl}, {18'd0, exp_c});
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input string tag, input logic [7:0] op, input logic c, input logic z,
                           input int len, input logic [13:0] e2, input logic [13:0] e3,
                           input logic [13:0] e4, input logic [13:0] e5);
    logic [13:0] ex [6];
    ex[0] = PC_OE | MAR_IE;
    ex[1] = RAM_OE | IR_IE | PC_STEP;
    ex[2] = e2; ex[3] = e3; ex[4] = e4; ex[5] = e5;
    opcode = op; flag_c = c; flag_z = z;
    for (int t = 0; t < len; t++) cyc($sformatf("%s_T%0d", tag, t), t[2:0], ex[t]);
    #1;
    chk({tag, "_wrap"}, {29'd0, tstate}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; opcode = 8'h00; flag_c = 1'b0; flag_z = 1'b0;
    @(posedge clk); #1;
    #1;
    chk("rst_ctrl", {18'd0, ctrl}, 32'd0);
    chk("rst_t", {29'd0, tstate}, 32'd0);
    chk("rst_halt", {31'd0, halted}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr("nop",   8'h00, 0, 0, 3, NONE, NONE, NONE, NONE);
    run_instr("lda",   8'h15, 0, 0, 5, PC_OE|MAR_IE, RAM_OE|MAR_IE|PC_STEP, RAM_OE|A_IE, NONE);
    run_instr("add",   8'h20, 0, 0, 6, PC_OE|MAR_IE, RAM_OE|MAR_IE|PC_STEP, RAM_OE|B_IE,
              ALU_OE|A_IE|FLAGS_IE);
    run_instr("sub",   8'h30, 0, 0, 6, PC_OE|MAR_IE, RAM_OE|MAR_IE|PC_STEP, RAM_OE|B_IE,
              ALU_OE|A_IE|FLAGS_IE|ALU_SUB);
    run_instr("sta",   8'h40, 0, 0, 5, PC_OE|MAR_IE, RAM_OE|MAR_IE|PC_STEP, A_OE|RAM_WE, NONE);
    run_instr("ldi",   8'h57, 0, 0, 4, PC_OE|MAR_IE, RAM_OE|A_IE|PC_STEP, NONE, NONE);
    run_instr("jmp",   8'h60, 0, 0, 4, PC_OE|MAR_IE, RAM_OE|PC_IE, NONE, NONE);
    run_instr("jc1",   8'h70, 1, 0, 4, PC_OE|MAR_IE, RAM_OE|PC_IE, NONE, NONE);
    run_instr("jc0",   8'h70, 0, 1, 4, PC_OE|MAR_IE, PC_STEP, NONE, NONE);
    run_instr("jz1",   8'h80, 0, 1, 4, PC_OE|MAR_IE, RAM_OE|PC_IE, NONE, NONE);
    run_instr("jz0",   8'h80, 1, 0, 4, PC_OE|MAR_IE, PC_STEP, NONE, NONE);
    run_instr("out",   8'hE0, 0, 0, 3, A_OE|OUT_IE, NONE, NONE, NONE);
    run_instr("ill9",  8'h9A, 1, 1, 3, NONE, NONE, NONE, NONE);

    // HLT: three cycles, then parked with everything low regardless of inputs.
    run_instr("hlt",   8'hF0, 0, 0, 3, NONE, NONE, NONE, NONE);
    chk("hlt_set", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      opcode = (i % 2 == 0) ? 8'h10 : 8'h20;
      flag_c = i[0]; flag_z = i[1];
      #1;
      chk($sformatf("hlt_c%0d", i), {18'd0, ctrl}, 32'd0);
      chk($sformatf("hlt_t%0d", i), {29'd0, tstate}, 32'd0);
      chk($sformatf("hlt_h%0d", i), {31'd0, halted}, 32'd1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("hltrst_c", {18'd0, ctrl}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("hltrst_h", {31'd0, halted}, 32'd0);
    chk("hltrst_t", {29'd0, tstate}, 32'd0);
    run_instr("post_hlt", 8'h00, 0, 0, 3, NONE, NONE, NONE, NONE);

    // Reset in T4 of ADD.
    opcode = 8'h20;
    cyc("mid_T0", 3'd0, PC_OE|MAR_IE);
    cyc("mid_T1", 3'd1, RAM_OE|IR_IE|PC_STEP);
    cyc("mid_T2", 3'd2, PC_OE|MAR_IE);
    cyc("mid_T3", 3'd3, RAM_OE|MAR_IE|PC_STEP);
    rst = 1'b1;
    #1;
    chk("mid_T4_t", {29'd0, tstate}, 32'd4);
    chk("mid_T4_c", {18'd0, ctrl}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr("mid_restart", 8'h15, 0, 0, 5, PC_OE|MAR_IE, RAM_OE|MAR_IE|PC_STEP, RAM_OE|A_IE, NONE);

    // Random stream with occasional resets: structural invariants only.
    for (int i = 0; i < 10000; i++) begin
      opcode = 8'($urandom);
      flag_c = 1'($urandom);
      flag_z = 1'($urandom);
      rst    = ($urandom_range(0, 99) == 0);
      #1;
      chk("rnd_oe", {31'd0, ({3'd0, pc_oe} + {3'd0, ram_oe} + {3'd0, a_oe} + {3'd0, alu_oe}) <= 4'd1}, 32'd1);
      chk("rnd_pc", {31'd0, pc_ie & pc_step}, 32'd0);
      chk("rnd_t", {31'd0, tstate <= 3'd5}, 32'd1);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
